// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared defaults for the free-running preloadable counter.
//   COUNTER_WIDTH_DEFAULT     : default counter / preload / output width
//   COUNTER_RESET_VAL_DEFAULT : default value forced onto qout during reset
//   next_count()              : wrap-around successor of a count value
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT     = 8;
    localparam int COUNTER_RESET_VAL_DEFAULT = 0;

    // Successor of a count value, wrapping modulo 2**width. The caller passes
    // its value zero-extended to 32 bits and truncates the result back to its
    // own width.
    function automatic logic [31:0] next_count(input logic [31:0] value,
                                               input int          width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value + 32'd1) & mask;
    endfunction

endpackage : counter_pkg

// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//   Free-running WIDTH-bit up-counter with synchronous parallel preload.
//   Advances by one on every rising clk edge, wrapping modulo 2**WIDTH.
//   A preload strobe loads pl_data on the next edge instead of incrementing.
//   There is no handshake with neighbouring blocks.
//
//   Ports
//     clk      in   1      sole clock, rising edge
//     reset    in   1      asynchronous, active-high; forces qout = RESET_VAL
//     preload  in   1      synchronous load strobe, active-high
//     pl_data  in   WIDTH  value loaded when preload = 1
//     qout     out  WIDTH  current count, straight from the state register
//
//   Priority: reset > preload > increment.
// ---------------------------------------------------------------------------
module counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = COUNTER_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(COUNTER_RESET_VAL_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preload,
    input  logic [WIDTH-1:0] pl_data,
    output logic [WIDTH-1:0] qout
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-state mux: a load replaces the increment for that edge only.
    always_comb begin
        count_d = WIDTH'(next_count(32'(count_q), WIDTH));
        if (preload) begin
            count_d = pl_data;
        end
    end

    // The clear is asynchronous, so any load pending in the same cycle is
    // simply lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    // Register output only: no combinational path from inputs to qout.
    assign qout = count_q;

`ifdef COUNTER_ASSERT_ON
    // Remembers the inputs and count seen at the previous edge so the current
    // count can be checked against what that edge should have produced.
    logic             chk_valid;
    logic             chk_preload;
    logic [WIDTH-1:0] chk_data;
    logic [WIDTH-1:0] chk_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_valid   <= 1'b0;
            chk_preload <= 1'b0;
            chk_data    <= '0;
            chk_count   <= RESET_VAL;
        end else begin
            chk_valid   <= 1'b1;
            chk_preload <= preload;
            chk_data    <= pl_data;
            chk_count   <= count_q;
            if (chk_valid) begin
                assert (count_q == (chk_preload ? chk_data
                                                : WIDTH'(chk_count + 1'b1)))
                    else $error("counter: load/increment/wrap invariant broken");
            end
        end
    end
`endif

endmodule : counter

// File: tb/tb_counter.sv
// Testbench for counter: directed scenarios followed by randomized stimulus,
// all compared against a modulo-arithmetic reference model.
module tb_counter;

  localparam int W   = 8;
  localparam int MOD = 1 << W;
  localparam int RST = 0;

  // clock / reset block
  logic         clk = 1'b0;
  logic         reset;
  logic         preload;
  logic [W-1:0] pl_data;
  logic [W-1:0] qout;

  always #5 clk = ~clk;

  counter #(.WIDTH(W), .RESET_VAL(W'(RST))) dut (
    .clk     (clk),
    .reset   (reset),
    .preload (preload),
    .pl_data (pl_data),
    .qout    (qout)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           model_cnt;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got,
                           input logic [W-1:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: qout=%0d expected=%0d at t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference model: what the count must be after one rising edge, given the
  // inputs held across that edge.
  task automatic model_edge();
    if (reset)        model_cnt = RST;
    else if (preload) model_cnt = int'(pl_data);
    else              model_cnt = (model_cnt + 1) % MOD;
    exp_q.push_back(W'(model_cnt));
  endtask

  // driver: one clock edge, then sample 1 ns later and compare
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_val(tag, qout, exp_q.pop_front());
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    reset     = 1'b1;
    preload   = 1'b0;
    pl_data   = '0;
    model_cnt = RST;

    // Reset: qout is RESET_VAL at once and throughout 3 clocks
    #1;
    check_val("reset_async", qout, W'(RST));
    run(3, "reset_hold");

    // Count: release, 30 clocks -> 1..30
    reset = 1'b0;
    run(30, "count");
    check_val("count_30", qout, W'(30));

    // Preload 50 for one clock, then 30 more -> 80
    preload = 1'b1; pl_data = W'(50);
    step("preload_50");
    check_val("preload_now_50", qout, W'(50));
    preload = 1'b0; pl_data = '0;
    run(30, "after_preload");
    check_val("count_80", qout, W'(80));

    // Wrap: preload 250, 10 clocks -> 4
    preload = 1'b1; pl_data = W'(250);
    step("preload_250");
    preload = 1'b0;
    run(10, "wrap");
    check_val("wrap_4", qout, W'(4));

    // All-ones preload wraps to 0 on the following edge
    preload = 1'b1; pl_data = W'(MOD - 1);
    step("preload_ones");
    preload = 1'b0;
    step("ones_wrap");
    check_val("ones_to_0", qout, W'(0));

    // Async reset between edges while qout = 80
    preload = 1'b1; pl_data = W'(80);
    step("preload_80");
    preload = 1'b0;
    #3;
    reset = 1'b1;
    model_cnt = RST;
    #1;
    check_val("async_clear", qout, W'(RST));
    preload = 1'b1; pl_data = W'(99);
    run(2, "reset_ignores_load");
    // release between edges: first increment at the next edge
    #2;
    reset   = 1'b0;
    preload = 1'b0;
    step("release_first_inc");
    check_val("release_1", qout, W'(RST + 1));

    // Held preload 7,8,9 then drop -> 10
    preload = 1'b1;
    for (int v = 7; v <= 9; v++) begin
      pl_data = W'(v);
      step("held_preload");
    end
    preload = 1'b0;
    step("held_release");
    check_val("held_10", qout, W'(10));

    // Randomized stimulus with occasional mid-cycle reset pulses
    for (int i = 0; i < 400; i++) begin
      preload = ($urandom_range(0, 3) == 0);
      pl_data = W'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 31) == 0) begin
        #2;
        reset = 1'b1;
        model_cnt = RST;
        #1;
        check_val("rand_async_clear", qout, W'(RST));
        step("rand_in_reset");
        #2;
        reset = 1'b0;
      end else begin
        step("random");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_counter
